// File: rtl/tile_lcd_writer_if.sv
// Request and LCD bus signals of tile_lcd_writer.
// The master side belongs to the map-scan block; the slave side is the writer.
interface tile_lcd_writer_if;
  logic       en_update;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       cmd_done;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_dcx;
  logic       lcd_wrx;
  logic       lcd_csx;

  modport master (
    output en_update, x, y, obj_code,
    input  cmd_done, busy, lcd_data, lcd_dcx, lcd_wrx, lcd_csx
  );

  modport slave (
    input  en_update, x, y, obj_code,
    output cmd_done, busy, lcd_data, lcd_dcx, lcd_wrx, lcd_csx
  );
endinterface

// File: rtl/tile_lcd_writer.sv
// tile_lcd_writer: sends a fixed panel init sequence, then turns each tile
// request into an 8080 8-bit write burst (column set, page set, memory write,
// solid RGB565 fill) and pulses cmd_done when the tile is written.
// Every bus byte takes two clocks: strobe low, then strobe high.
module tile_lcd_writer #(
  parameter int unsigned TILE_PX   = 20,
  parameter int unsigned INIT_WAIT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  tile_lcd_writer_if.slave bus
);
  localparam int unsigned NPIX   = TILE_PX * TILE_PX;
  localparam int unsigned PIX_W  = ($clog2(NPIX) > 16) ? $clog2(NPIX) : 16;
  localparam int unsigned WAIT_W = (INIT_WAIT > 2) ? $clog2(INIT_WAIT) : 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(NPIX - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);
  localparam logic [3:0]        HDR_PIX   = 4'd11;

  typedef enum logic [2:0] {
    S_INIT_SEND, S_INIT_WAIT, S_IDLE, S_LATCH, S_BURST, S_DONE
  } state_t;

  state_t            r_state, w_state;
  logic [2:0]        r_init_idx, w_init_idx;
  logic [WAIT_W-1:0] r_wait, w_wait;
  logic              r_en_prev;
  logic [3:0]        r_x, w_x, r_y, w_y;
  logic [2:0]        r_obj, w_obj;
  logic [15:0]       r_x0, w_x0, r_x1, w_x1, r_y0, w_y0, r_y1, w_y1;
  logic [15:0]       r_colour, w_colour;
  logic [3:0]        r_hdr, w_hdr;
  logic [PIX_W-1:0]  r_pix, w_pix;
  logic              r_lo, w_lo;
  logic [7:0]        r_data, w_data;
  logic              r_dcx, w_dcx, r_wrx, w_wrx, r_csx, w_csx;
  logic              w_load_init, w_load_burst;

  // State, bus and transaction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_INIT_SEND;
      r_init_idx <= '0;
      r_wait     <= '0;
      r_en_prev  <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_obj      <= '0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_colour   <= '0;
      r_hdr      <= '0;
      r_pix      <= '0;
      r_lo       <= 1'b0;
      r_data     <= '0;
      r_dcx      <= 1'b1;
      r_wrx      <= 1'b1;
      r_csx      <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_init_idx <= w_init_idx;
      r_wait     <= w_wait;
      r_en_prev  <= bus.en_update;
      r_x        <= w_x;
      r_y        <= w_y;
      r_obj      <= w_obj;
      r_x0       <= w_x0;
      r_x1       <= w_x1;
      r_y0       <= w_y0;
      r_y1       <= w_y1;
      r_colour   <= w_colour;
      r_hdr      <= w_hdr;
      r_pix      <= w_pix;
      r_lo       <= w_lo;
      r_data     <= w_data;
      r_dcx      <= w_dcx;
      r_wrx      <= w_wrx;
      r_csx      <= w_csx;
    end
  end

  // Next state, byte pointers and the byte presented at the next cycle A.
  // In INIT_SEND a high chip select marks the idle cycle before a group starts.
  always_comb begin
    w_state      = r_state;
    w_init_idx   = r_init_idx;
    w_wait       = r_wait;
    w_x          = r_x;
    w_y          = r_y;
    w_obj        = r_obj;
    w_x0         = r_x0;
    w_x1         = r_x1;
    w_y0         = r_y0;
    w_y1         = r_y1;
    w_colour     = r_colour;
    w_hdr        = r_hdr;
    w_pix        = r_pix;
    w_lo         = r_lo;
    w_data       = r_data;
    w_dcx        = r_dcx;
    w_wrx        = 1'b1;
    w_csx        = r_csx;
    w_load_init  = 1'b0;
    w_load_burst = 1'b0;

    case (r_state)
      S_INIT_SEND: begin
        w_csx = 1'b0;
        if (r_csx) begin
          w_load_init = 1'b1;
        end else if (r_wrx) begin
          if (r_init_idx == 3'd6) begin
            w_state = S_IDLE;
            w_csx   = 1'b1;
          end else if (r_init_idx <= 3'd1) begin
            w_state    = S_INIT_WAIT;
            w_wait     = '0;
            w_csx      = 1'b1;
            w_init_idx = r_init_idx + 3'd1;
          end else begin
            w_init_idx  = r_init_idx + 3'd1;
            w_load_init = 1'b1;
          end
        end
      end
      S_INIT_WAIT: begin
        if (r_wait == WAIT_LAST) w_state = S_INIT_SEND;
        else                     w_wait  = r_wait + 1'b1;
      end
      S_IDLE: begin
        if (bus.en_update && !r_en_prev) begin
          w_state = S_LATCH;
          w_x     = bus.x;
          w_y     = bus.y;
          w_obj   = bus.obj_code;
        end
      end
      S_LATCH: begin
        w_x0 = 16'(32'(r_x) * TILE_PX);
        w_x1 = w_x0 + 16'(TILE_PX - 1);
        w_y0 = 16'(32'(r_y) * TILE_PX);
        w_y1 = w_y0 + 16'(TILE_PX - 1);
        case (r_obj)
          3'b000:  w_colour = 16'h0000;
          3'b001:  w_colour = 16'h07E0;
          3'b010:  w_colour = 16'h03E0;
          3'b011:  w_colour = 16'hF800;
          3'b100:  w_colour = 16'hFFFF;
          default: w_colour = 16'hF81F;
        endcase
        if (r_y >= 4'd12) begin
          w_state = S_DONE;
        end else begin
          w_state      = S_BURST;
          w_hdr        = '0;
          w_pix        = '0;
          w_lo         = 1'b0;
          w_csx        = 1'b0;
          w_load_burst = 1'b1;
        end
      end
      S_BURST: begin
        if (r_wrx) begin
          if (r_hdr == HDR_PIX && r_pix == PIX_LAST && r_lo) begin
            w_state = S_DONE;
            w_csx   = 1'b1;
          end else begin
            w_load_burst = 1'b1;
            if (r_hdr != HDR_PIX) begin
              w_hdr = r_hdr + 4'd1;
            end else if (!r_lo) begin
              w_lo = 1'b1;
            end else begin
              w_lo  = 1'b0;
              w_pix = r_pix + 1'b1;
            end
          end
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_INIT_SEND;
    endcase

    if (w_load_init) begin
      w_wrx = 1'b0;
      case (w_init_idx)
        3'd0:    {w_dcx, w_data} = 9'h001;
        3'd1:    {w_dcx, w_data} = 9'h011;
        3'd2:    {w_dcx, w_data} = 9'h03A;
        3'd3:    {w_dcx, w_data} = 9'h155;
        3'd4:    {w_dcx, w_data} = 9'h036;
        3'd5:    {w_dcx, w_data} = 9'h128;
        default: {w_dcx, w_data} = 9'h029;
      endcase
    end

    if (w_load_burst) begin
      w_wrx = 1'b0;
      case (w_hdr)
        4'd0:    {w_dcx, w_data} = {1'b0, 8'h2A};
        4'd1:    {w_dcx, w_data} = {1'b1, w_x0[15:8]};
        4'd2:    {w_dcx, w_data} = {1'b1, w_x0[7:0]};
        4'd3:    {w_dcx, w_data} = {1'b1, w_x1[15:8]};
        4'd4:    {w_dcx, w_data} = {1'b1, w_x1[7:0]};
        4'd5:    {w_dcx, w_data} = {1'b0, 8'h2B};
        4'd6:    {w_dcx, w_data} = {1'b1, w_y0[15:8]};
        4'd7:    {w_dcx, w_data} = {1'b1, w_y0[7:0]};
        4'd8:    {w_dcx, w_data} = {1'b1, w_y1[15:8]};
        4'd9:    {w_dcx, w_data} = {1'b1, w_y1[7:0]};
        4'd10:   {w_dcx, w_data} = {1'b0, 8'h2C};
        default: {w_dcx, w_data} = {1'b1, w_lo ? w_colour[7:0] : w_colour[15:8]};
      endcase
    end
  end

  assign bus.lcd_data = r_data;
  assign bus.lcd_dcx  = r_dcx;
  assign bus.lcd_wrx  = r_wrx;
  assign bus.lcd_csx  = r_csx;
  assign bus.cmd_done = (r_state == S_DONE);
  assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_tile_lcd_writer.sv
// Bench for tile_lcd_writer: directed and random tiles against a byte-list
// reference model, plus init sequence, invalid row, retrigger and reset abort.
module tb_tile_lcd_writer;
  localparam int TP = 20;
  localparam int IW = 1000;

  logic clk;
  logic rst;
  tile_lcd_writer_if bus();

  tile_lcd_writer #(.TILE_PX(TP), .INIT_WAIT(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  // Monitor state: one sample per cycle on the falling edge
  int         ncyc        = 0;
  logic       prev_wrx    = 1'b1;
  logic       prev_csx    = 1'b1;
  int         hi_run      = 0;
  int         wrx_low_cnt = 0;
  int         cs_low_cnt  = 0;
  logic [8:0] got_b[$];
  int         got_t[$];
  int         done_t[$];
  int         runs[$];
  logic [8:0] exp_q[$];
  logic [8:0] init_exp [7] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h128, 9'h029};

  // Capture each byte on the strobe rising edge, done pulses and chip-select gaps
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (prev_wrx === 1'b0 && bus.lcd_wrx === 1'b1) begin
      got_b.push_back({bus.lcd_dcx, bus.lcd_data});
      got_t.push_back(ncyc + 1);
    end
    if (bus.cmd_done === 1'b1) done_t.push_back(ncyc + 1);
    if (bus.lcd_wrx === 1'b0) wrx_low_cnt <= wrx_low_cnt + 1;
    if (bus.lcd_csx === 1'b0) cs_low_cnt <= cs_low_cnt + 1;
    if (bus.lcd_csx === 1'b1) begin
      hi_run <= hi_run + 1;
    end else begin
      if (prev_csx === 1'b1) runs.push_back(hi_run);
      hi_run <= 0;
    end
    prev_wrx <= bus.lcd_wrx;
    prev_csx <= bus.lcd_csx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int colour_of(input int obj);
    case (obj)
      0:       return 'h0000;
      1:       return 'h07E0;
      2:       return 'h03E0;
      3:       return 'hF800;
      4:       return 'hFFFF;
      default: return 'hF81F;
    endcase
  endfunction

  // Reference: the full byte list {dcx,data} a tile request must produce
  task automatic model_tile(input int tx, input int ty, input int tobj);
    int x0, x1, y0, y1, col;
    exp_q.delete();
    if (ty >= 12) return;
    x0  = tx * TP;
    x1  = x0 + TP - 1;
    y0  = ty * TP;
    y1  = y0 + TP - 1;
    col = colour_of(tobj);
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'(x0 >> 8)});
    exp_q.push_back({1'b1, 8'(x0)});
    exp_q.push_back({1'b1, 8'(x1 >> 8)});
    exp_q.push_back({1'b1, 8'(x1)});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'(y0 >> 8)});
    exp_q.push_back({1'b1, 8'(y0)});
    exp_q.push_back({1'b1, 8'(y1 >> 8)});
    exp_q.push_back({1'b1, 8'(y1)});
    exp_q.push_back({1'b0, 8'h2C});
    for (int p = 0; p < TP * TP; p++) begin
      exp_q.push_back({1'b1, 8'(col >> 8)});
      exp_q.push_back({1'b1, 8'(col)});
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (bus.busy !== 1'b0 && n < budget);
    chk("idle_reached", 32'(bus.busy), 0);
  endtask

  // Releases reset and checks the init byte sequence and the waits between groups
  task automatic check_init();
    int gb, rb;
    gb  = got_b.size();
    rb  = runs.size();
    rst = 1'b0;
    wait_idle(6000);
    chk("init_nbytes", got_b.size() - gb, 7);
    for (int i = 0; i < 7; i++)
      if (gb + i < got_b.size())
        chk($sformatf("init_byte%0d", i), 32'(got_b[gb+i]), 32'(init_exp[i]));
    chk("init_ngroups", runs.size() - rb, 3);
    if (runs.size() >= rb + 3) begin
      chk("init_wait1_ge", 32'(runs[rb+1] >= IW), 1);
      chk("init_wait2_ge", 32'(runs[rb+2] >= IW), 1);
    end
  endtask

  task automatic run_tile(input int tx, input int ty, input int tobj,
                          input int glitch, input int hold);
    int mark, gb, db, wb, cb, nb, e;
    wait_idle(4000);
    @(negedge clk); #1;
    bus.x         = 4'(tx);
    bus.y         = 4'(ty);
    bus.obj_code  = 3'(tobj);
    bus.en_update = 1'b1;
    mark = ncyc;
    gb   = got_b.size();
    db   = done_t.size();
    wb   = wrx_low_cnt;
    cb   = cs_low_cnt;
    model_tile(tx, ty, tobj);
    nb = exp_q.size();
    e  = (ty >= 12) ? 2 : 2 * nb + 2;
    for (int k = 1; k <= e + hold + 5; k++) begin
      @(negedge clk); #1;
      if (k == glitch - 2) bus.en_update = 1'b0;
      if (k == glitch)     bus.en_update = 1'b1;
    end
    bus.en_update = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk($sformatf("done_count_t%0d_%0d", tx, ty), done_t.size() - db, 1);
    if (done_t.size() > db)
      chk($sformatf("done_cycle_t%0d_%0d", tx, ty), done_t[db] - mark, e);
    chk($sformatf("nbytes_t%0d_%0d", tx, ty), got_b.size() - gb, nb);
    for (int i = 0; i < nb; i++) begin
      if (gb + i >= got_b.size()) break;
      chk($sformatf("byte%0d_t%0d_%0d", i, tx, ty), 32'(got_b[gb+i]), 32'(exp_q[i]));
      if (got_b[gb+i] !== exp_q[i]) break;
    end
    if (nb > 0 && got_b.size() >= gb + nb) begin
      chk("first_byte_cycle", got_t[gb] - mark, 3);
      chk("last_byte_cycle", got_t[gb+nb-1] - mark, 2 * nb + 1);
    end
    if (nb == 0) begin
      chk("inv_wrx_low", wrx_low_cnt - wb, 0);
      chk("inv_csx_low", cs_low_cnt - cb, 0);
    end
    chk("busy_after_tile", 32'(bus.busy), 0);
  endtask

  // Reset lands in cycle A of the first byte of pixel 200 (byte 411)
  task automatic reset_mid_burst(input int tx, input int ty, input int tobj);
    int db;
    wait_idle(4000);
    @(negedge clk); #1;
    bus.x         = 4'(tx);
    bus.y         = 4'(ty);
    bus.obj_code  = 3'(tobj);
    bus.en_update = 1'b1;
    db = done_t.size();
    for (int k = 1; k <= 2 + 2 * 411; k++) begin
      @(negedge clk); #1;
    end
    chk("pre_rst_wrx", 32'(bus.lcd_wrx), 0);
    chk("pre_rst_csx", 32'(bus.lcd_csx), 0);
    rst = 1'b1;
    #1;
    chk("abort_csx", 32'(bus.lcd_csx), 1);
    chk("abort_wrx", 32'(bus.lcd_wrx), 1);
    chk("abort_busy", 32'(bus.busy), 1);
    chk("abort_cmd_done", 32'(bus.cmd_done), 0);
    bus.en_update = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_done", done_t.size() - db, 0);
    check_init();
  endtask

  initial begin
    rst           = 1'b1;
    bus.en_update = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.obj_code  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_csx", 32'(bus.lcd_csx), 1);
    chk("rst_wrx", 32'(bus.lcd_wrx), 1);
    chk("rst_dcx", 32'(bus.lcd_dcx), 1);
    chk("rst_data", 32'(bus.lcd_data), 0);
    chk("rst_cmd_done", 32'(bus.cmd_done), 0);
    chk("rst_busy", 32'(bus.busy), 1);

    check_init();

    run_tile(0, 0, 4, -1, 0);
    run_tile(15, 11, 3, -1, 0);
    run_tile(3, 12, 0, -1, 0);
    run_tile(7, 5, 2, 100, 40);
    for (int r = 0; r < 4; r++)
      run_tile(int'($urandom_range(15)), int'($urandom_range(13)), int'($urandom_range(7)), -1, 0);

    reset_mid_burst(5, 6, 1);
    run_tile(2, 9, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tile_lcd_writer.md
# tile_lcd_writer

Downstream display stage of the snake image generator. Takes one tile-update request (grid x, y, obj_code) from the map-scan block, converts it to an ILI9341-style 8080 8-bit parallel write burst (column set, page set, memory write, solid RGB565 fill) and pulses `cmd_done` back to the scanner when the tile is fully written. After reset it first sends a fixed panel-initialisation sequence.

## Interface
- `TILE_PX`, 20: tile edge in pixels. The 16x12 grid maps onto 320x240.
- `INIT_WAIT`, 1000: idle cycles inserted after the soft-reset command and after the sleep-out command.
- `clk` input 1: sole clock.
- `rst` input 1: asynchronous, active-high reset.
- `en_update` input 1: tile request from the scanner. Accepted on its rising edge only.
- `x` input 4: tile column, 0-15.
- `y` input 4: tile row, 0-11. Rows 12-15 are invalid.
- `obj_code` input 3: 000 empty, 001 head, 010 body, 011 apple, 100 border, 101-111 undefined.
- `cmd_done` output 1: one-cycle pulse when a request completes.
- `busy` output 1: high during init and during a tile transaction.
- `lcd_data` output 8: parallel bus byte.
- `lcd_dcx` output 1: 0 = command byte, 1 = data byte.
- `lcd_wrx` output 1: active-low write strobe. The panel latches on its rising edge.
- `lcd_csx` output 1: active-low chip select.

## Operation
- **States:** INIT_SEND, INIT_WAIT, IDLE, LATCH, BURST, DONE.
- **INIT:** bytes are C = command, D = data.
  - Sequence: C01, wait INIT_WAIT, C11, wait INIT_WAIT, C3A D55, C36 D28, C29.
  - Then go to IDLE.
  - `en_update` edges during init are dropped.
- **IDLE:** `en_update` is registered each cycle.
  - Accept when `en_update`=1 and its previous registered value was 0.
  - On accept, latch x, y and obj_code.
  - An edge while `busy` is dropped and not queued.
  - Holding `en_update` high after `cmd_done` does not retrigger.
- **LATCH (one cycle):** compute 16-bit coordinates.
  - x0 = x*TILE_PX, x1 = x0+TILE_PX-1.
  - y0 = y*TILE_PX, y1 = y0+TILE_PX-1.
  - Select colour: 000→0000, 001→07E0, 010→03E0, 011→F800, 100→FFFF, 101-111→F81F.
  - If latched y ≥ 12: no bus activity, go straight to DONE.
- **BURST:** byte order is
  - C2A, D x0[15:8], D x0[7:0], D x1[15:8], D x1[7:0];
  - C2B, D y0[15:8], D y0[7:0], D y1[15:8], D y1[7:0];
  - C2C;
  - then TILE_PX² pixels, each colour[15:8] followed by colour[7:0].
  - Total bytes B = 11 + 2·TILE_PX² (811 at the default).
  - A 16-bit pixel counter and a 4-bit header index track progress.
- **DONE (one cycle):** `cmd_done`=1, then return to IDLE.

## Timing
- **Byte cycle:** exactly 2 clocks. Cycle A has `lcd_wrx`=0; cycle B has `lcd_wrx`=1.
  - `lcd_data` and `lcd_dcx` update only at the start of cycle A.
  - Both hold through cycle B.
- **Chip select:** `lcd_csx`=0 from the first cycle A through the last cycle B of each contiguous group.
  - Groups are: each init segment between waits, and each tile burst.
  - `lcd_csx` is 1 in IDLE, INIT_WAIT, LATCH and DONE.
- **Tile latency** (accept edge = edge 0):
  - LATCH in cycle 1.
  - Byte k has cycle A at cycle 2+2k.
  - Last cycle B at cycle 2B+1.
  - `cmd_done` high in cycle 2B+2 (1624 at the default); IDLE from cycle 2B+3.
  - For an invalid row, `cmd_done` is high in cycle 2.
- **Reset values:** `lcd_csx`=1, `lcd_wrx`=1, `lcd_dcx`=1, `lcd_data`=00, `cmd_done`=0, `busy`=1, state INIT_SEND.
  - `busy` falls on entering IDLE.
- **Reset mid-burst:** outputs go to reset values immediately (asynchronous).
  - No `cmd_done` is issued.
  - On release, init restarts from C01.
- **Arithmetic:** x1 max = 319 and y1 max = 239 at the default. No truncation is allowed at any TILE_PX ≤ 4095.

## Test plan
- **Reset, then release:** the bus shows C01, then ≥INIT_WAIT cycles with `lcd_csx`=1, then C11, wait, C3A D55 C36 D28 C29; then `busy` 1→0.
- **Tile x=0, y=0, obj_code=100:** bytes 2A 00 00 00 13, 2B 00 00 00 13, 2C, then 800 bytes of FF. `cmd_done` is high exactly at cycle 1624 after the accept edge, for one cycle.
- **Tile x=15, y=11, obj_code=011:** bytes 2A 01 2C 01 3F, 2B 00 DC 00 EF, 2C, then 400 × (F8, 00). `lcd_dcx` is 0 only on the three command bytes.
- **Tile x=3, y=12:** no `lcd_wrx` low and `lcd_csx` stays 1. `cmd_done` is high at cycle 2.
- **Second `en_update` rising edge at cycle 100 of a burst, and `en_update` held high through `cmd_done`:** exactly one `cmd_done`, and no further burst starts.
- **`rst` pulsed during pixel 200:** `lcd_csx`, `lcd_wrx` and `busy` go to 1/1/1 asynchronously, no `cmd_done` is issued, and init restarts with C01.
